// File: rtl/bcd_seg7_scanner_pkg.sv
// Shared types and segment codes for the 3-digit BCD seven-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package bcd_seg7_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIG0 = 2'd1,
        ST_DIG1 = 2'd2,
        ST_DIG2 = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] d100;
        logic [3:0] d10;
        logic [3:0] d1;
    } bcd3_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg7_scanner_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes show a dash
// and raise the invalid flag.
module bcd_to_seg7
    import bcd_seg7_scanner_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg,
    output logic       invalid
);

    always_comb begin
        invalid = 1'b0;
        unique case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: begin
                seg     = SEG_DASH;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Buffers one 3-digit BCD value and scans it onto a multiplexed 3-digit display.
// A new value replaces the shown one only at a frame boundary, so frames never tear.
module bcd_seg7_scanner
    import bcd_seg7_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int BLANK_LZ     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    input  logic [3:0] d100,
    input  logic [3:0] d10,
    input  logic [3:0] d1,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       digit_err
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bcd3_t            pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    bcd3_t            disp_q, disp_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             digit_err_q, digit_err_d;

    logic [3:0]       cur_digit;
    logic [2:0]       slot_an;
    logic             lz_blank;
    logic [6:0]       dec_seg;
    logic             dec_invalid;

    // Handshake: a transfer happens on a rising edge where bcd_valid && bcd_ready;
    // bcd_ready is just the inverted pending-full flop, so the source must hold data while it is low.
    assign bcd_ready = !pend_full_q;
    assign seg       = seg_q;
    assign an        = an_q;
    assign digit_err = digit_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            disp_q      <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= 3'b000;
            digit_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            disp_q      <= disp_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            digit_err_q <= digit_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;

        if (bcd_valid && !pend_full_q) begin
            pend_d      = {d100, d10, d1};
            pend_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    disp_d      = pend_q;
                    pend_full_d = 1'b0;
                    state_d     = ST_DIG0;
                    cnt_d       = '0;
                end
            end
            default: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    unique case (state_q)
                        ST_DIG0: state_d = ST_DIG1;
                        ST_DIG1: state_d = ST_DIG2;
                        default: begin
                            // Frame boundary: the only place the shown value may change.
                            state_d = ST_DIG0;
                            if (pend_full_q) begin
                                disp_d      = pend_q;
                                pend_full_d = 1'b0;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        cur_digit = disp_q.d1;
        slot_an   = 3'b001;
        lz_blank  = 1'b0;
        unique case (state_q)
            ST_DIG1: begin
                cur_digit = disp_q.d10;
                slot_an   = 3'b010;
                lz_blank  = (BLANK_LZ != 0) && (disp_q.d100 == 4'd0) && (disp_q.d10 == 4'd0);
            end
            ST_DIG2: begin
                cur_digit = disp_q.d100;
                slot_an   = 3'b100;
                lz_blank  = (BLANK_LZ != 0) && (disp_q.d100 == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit   (cur_digit),
        .seg     (dec_seg),
        .invalid (dec_invalid)
    );

    // Blanked leading zeros keep their anode on so every slot has the same duty.
    always_comb begin
        an_d        = 3'b000;
        seg_d       = SEG_OFF;
        digit_err_d = digit_err_q;
        if (state_q != ST_IDLE && cnt_q >= CNT_BLANK) begin
            an_d  = slot_an;
            seg_d = lz_blank ? SEG_OFF : dec_seg;
            if (dec_invalid) begin
                digit_err_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Directed bench for bcd_seg7_scanner with REFRESH_DIV=4, BLANK_CYCLES=1, BLANK_LZ=1.
// A frame is 12 cycles: per slot one dark cycle then three lit cycles.
module tb_bcd_seg7_scanner;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bcd_valid = 1'b0;
    logic       bcd_ready;
    logic [3:0] d100 = '0;
    logic [3:0] d10 = '0;
    logic [3:0] d1 = '0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       digit_err;

    int n_tests = 0;
    int n_fail  = 0;
    int p0, p1;

    always #5 clk = ~clk;

    bcd_seg7_scanner #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (1),
        .BLANK_LZ     (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .d100      (d100),
        .d10       (d10),
        .d1        (d1),
        .seg       (seg),
        .an        (an),
        .digit_err (digit_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bcd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer a value from IDLE and advance to the first dark cycle of the first frame.
    task automatic start(input string tag, input logic [11:0] v);
        {d100, d10, d1} = v;
        bcd_valid = 1'b1;
        chk({tag, " ready_before"}, bcd_ready, 1);
        tick();
        bcd_valid = 1'b0;
        chk({tag, " ready_after_acc"}, bcd_ready, 0);
        chk({tag, " an_idle"}, an, 3'b000);
        tick();
        chk({tag, " ready_drained"}, bcd_ready, 1);
        tick();
    endtask

    // Check one full frame starting at its first dark cycle; optionally offer up
    // to two values (offer index < 0 disables). Source holds each offer until accepted.
    task automatic frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input int a0, input logic [11:0] v0,
                         input int a1, input logic [11:0] v1, output int q0, output int q1);
        logic [6:0]  e[3];
        logic [11:0] src_data;
        logic [2:0]  exp_an;
        logic [6:0]  exp_seg;
        bit          src_hold;
        bit          acc;
        int          nxt;
        int          cur;
        e[0] = e0; e[1] = e1; e[2] = e2;
        q0 = -1; q1 = -1;
        nxt = (a0 >= 0) ? 0 : 1;
        cur = 0;
        src_hold = 1'b0;
        src_data = '0;
        for (int c = 0; c < 3 * RD; c++) begin
            if (!src_hold) begin
                if (nxt == 0 && c >= a0) begin
                    src_hold = 1'b1; src_data = v0; cur = 0; nxt = 1;
                end else if (nxt == 1 && a1 >= 0 && c >= a1) begin
                    src_hold = 1'b1; src_data = v1; cur = 1; nxt = 2;
                end
            end
            bcd_valid = src_hold;
            {d100, d10, d1} = src_data;
            acc = src_hold && bcd_ready;
            exp_an  = ((c % RD) == 0) ? 3'b000 : (3'b001 << (c / RD));
            exp_seg = ((c % RD) == 0) ? 7'h00 : e[c / RD];
            chk($sformatf("%s an c%0d", tag, c), an, exp_an);
            chk($sformatf("%s seg c%0d", tag, c), seg, exp_seg);
            tick();
            if (acc) begin
                if (cur == 0) q0 = c; else q1 = c;
                src_hold  = 1'b0;
                bcd_valid = 1'b0;
            end
        end
        bcd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset state, then 243 scanning for two frames
        do_reset();
        chk("rst an", an, 3'b000);
        chk("rst seg", seg, 7'h00);
        chk("rst ready", bcd_ready, 1);
        chk("rst err", digit_err, 0);
        start("t1", 12'h243);
        frame("t1 f0", 7'h4F, 7'h66, 7'h5B, -1, '0, -1, '0, p0, p1);
        frame("t1 f1", 7'h4F, 7'h66, 7'h5B, -1, '0, -1, '0, p0, p1);

        // 4. back-to-back offers (also covers 0,0,7 and 0,5,0 blanking)
        frame("t4 f0", 7'h4F, 7'h66, 7'h5B, 2, 12'h007, 5, 12'h050, p0, p1);
        chk("t4 acc1_pos", p0, 2);
        chk("t4 acc2_waits_to_boundary", p1, 11);
        chk("t4 ready_low_pend", bcd_ready, 0);
        frame("t4 f1 007", 7'h07, 7'h00, 7'h00, -1, '0, -1, '0, p0, p1);
        chk("t4 ready_after_swap", bcd_ready, 1);
        frame("t4 f2 050", 7'h3F, 7'h6D, 7'h00, -1, '0, -1, '0, p0, p1);
        chk("t4 err_clean", digit_err, 0);

        // 5. invalid tens digit
        do_reset();
        start("t5", 12'h0C5);
        chk("t5 err_before", digit_err, 0);
        frame("t5 f0 0C5", 7'h6D, 7'h40, 7'h00, 0, 12'h123, -1, '0, p0, p1);
        chk("t5 acc_pos", p0, 0);
        chk("t5 err_set", digit_err, 1);
        frame("t5 f1 123", 7'h4F, 7'h5B, 7'h06, -1, '0, -1, '0, p0, p1);
        chk("t5 err_sticky", digit_err, 1);
        do_reset();
        chk("t5 err_cleared", digit_err, 0);

        // 6. reset inside the tens slot with a value pending
        start("t6", 12'h243);
        {d100, d10, d1} = 12'h050;
        bcd_valid = 1'b1;
        tick();
        bcd_valid = 1'b0;
        chk("t6 pend_full", bcd_ready, 0);
        repeat (4) tick();
        chk("t6 an_tens", an, 3'b010);
        chk("t6 seg_tens", seg, 7'h66);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 an_rst", an, 3'b000);
        chk("t6 seg_rst", seg, 7'h00);
        chk("t6 ready_rst", bcd_ready, 1);
        repeat (20) tick();
        chk("t6 an_idle", an, 3'b000);
        chk("t6 seg_idle", seg, 7'h00);
        chk("t6 ready_idle", bcd_ready, 1);
        start("t6b", 12'h007);
        frame("t6 f0 007", 7'h07, 7'h00, 7'h00, -1, '0, -1, '0, p0, p1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
